// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the physical-memory responder and its bus.
package pmem_responder_pkg;

  localparam int unsigned PMEM_OFFSET_BITS = 4;
  localparam int unsigned PMEM_LINE_BITS   = 128;
  localparam int unsigned PMEM_ADDR_BITS   = 16;
  localparam int unsigned PMEM_CNT_BITS    = 4;

  typedef logic [PMEM_LINE_BITS-1:0] lc3b_pmem_line;
  typedef logic [PMEM_ADDR_BITS-1:0] lc3b_word;

  // Line-granular address: the byte offset within a line is discarded.
  function automatic lc3b_word pmem_line_addr(input lc3b_word addr);
    return addr >> PMEM_OFFSET_BITS;
  endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// pmem_* bus between the cache controller (master) and the memory responder (slave).
interface pmem_responder_if;
  import pmem_responder_pkg::*;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_pmem_line pmem_wdata;
  logic          pmem_resp;
  lc3b_pmem_line pmem_rdata;
  logic          mem_ready;
  logic          pmem_error;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_resp,
    input  pmem_rdata,
    input  mem_ready,
    input  pmem_error
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_resp,
    output pmem_rdata,
    output mem_ready,
    output pmem_error
  );

endinterface

// File: rtl/pmem_line_array.sv
// Synchronous single-port line store with a registered, read-enabled output.
module pmem_line_array
  import pmem_responder_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [INDEX_BITS-1:0] index_i,
  input  lc3b_pmem_line         wdata_i,
  output lc3b_pmem_line         rdata_o
);

  localparam int unsigned DEPTH = 2 ** INDEX_BITS;

  lc3b_pmem_line mem_q [DEPTH];
  lc3b_pmem_line rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[index_i] <= wdata_i;
    end
  end

  // Output only updates on a read so the last read line stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[index_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder: zero-initialises a line store, then serves one line
// read or write per handshake with a fixed response latency.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  pmem_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_DONE
  } state_e;

  typedef logic [INDEX_BITS-1:0]    idx_t;
  typedef logic [PMEM_CNT_BITS-1:0] cnt_t;

  localparam cnt_t CNT_LOAD = cnt_t'(LATENCY - 1);

  state_e        state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  idx_t          init_q, init_d;
  idx_t          idx_q, idx_d;
  logic          wr_q, wr_d;
  lc3b_pmem_line wdata_q, wdata_d;
  logic          err_q, err_d;

  logic          arr_we;
  logic          arr_re;
  idx_t          arr_idx;
  lc3b_pmem_line arr_wdata;
  lc3b_pmem_line arr_rdata;

  logic          req;
  idx_t          req_idx;
  logic          unused_addr;

  assign req         = bus.pmem_read | bus.pmem_write;
  assign req_idx     = idx_t'(pmem_line_addr(bus.pmem_address));
  assign unused_addr = ^bus.pmem_address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      init_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_d    = init_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_idx   = idx_q;
    arr_wdata = wdata_q;

    unique case (state_q)
      S_INIT: begin
        arr_we    = 1'b1;
        arr_idx   = init_q;
        arr_wdata = '0;
        if (init_q == '1) begin
          state_d = S_IDLE;
        end else begin
          init_d = init_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (req) begin
          idx_d   = req_idx;
          wr_d    = bus.pmem_write;
          wdata_d = bus.pmem_wdata;
          cnt_d   = CNT_LOAD;
          if (bus.pmem_read && bus.pmem_write) begin
            err_d = 1'b1;
          end
          // With unit latency the read must be launched from the live address,
          // since the capture registers only load on this same edge.
          if (LATENCY == 1) begin
            state_d = S_RESP;
            arr_idx = req_idx;
            arr_re  = !bus.pmem_write;
          end else begin
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          if ((wr_q && bus.pmem_read) || (!wr_q && bus.pmem_write)) begin
            err_d = 1'b1;
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == cnt_t'(1)) begin
            state_d = S_RESP;
            arr_re  = !wr_q;
          end
        end
      end

      S_RESP: begin
        arr_we  = wr_q;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (!req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  pmem_line_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .index_i (arr_idx),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  assign bus.pmem_resp  = (state_q == S_RESP);
  assign bus.pmem_rdata = arr_rdata;
  assign bus.mem_ready  = (state_q != S_INIT);
  assign bus.pmem_error = err_q;

endmodule
